// File: rtl/adc_decimator_frontend_if.sv
// Bundle between the ADC capture logic and the effects chain.
// The master side (ADC/control) drives run enable and the code strobe;
// the slave side (decimator) returns decimated samples and the clip flag.
interface adc_decimator_frontend_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16
);
  logic                    enable;
  logic                    adc_valid;
  logic [IN_W-1:0]         adc_data;
  logic signed [OUT_W-1:0] sample_out;
  logic                    sample_valid;
  logic                    clip_led;

  modport master (
    output enable, adc_valid, adc_data,
    input  sample_out, sample_valid, clip_led
  );

  modport slave (
    input  enable, adc_valid, adc_data,
    output sample_out, sample_valid, clip_led
  );
endinterface

// File: rtl/adc_decimator_frontend.sv
// ADC capture front end: drops a warm-up burst, box-car averages and
// decimates by 2**DECIM_LOG2, converts offset-binary codes to signed
// samples and drives a stretched clip indicator.
// Optional feature: define ADC_DC_BLOCK_EN to build a first-order DC
// removal stage on the decimated samples.
module adc_decimator_frontend #(
  parameter int IN_W       = 12,
  parameter int OUT_W      = 16,
  parameter int DECIM_LOG2 = 2,
  parameter int WARMUP     = 16,
  parameter int CLIP_HOLD  = 2500000,
  parameter int DC_SHIFT   = 10
) (
  input logic clk,
  input logic rst_n,
  adc_decimator_frontend_if.slave bus
);

  localparam int ACC_W  = IN_W + DECIM_LOG2;
  localparam int DCNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int CCNT_W = (CLIP_HOLD > 0) ? $clog2(CLIP_HOLD + 1) : 1;

  localparam logic [DCNT_W-1:0] DEC_LAST  = DCNT_W'((1 << DECIM_LOG2) - 1);
  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP - 1);
  localparam logic [CCNT_W-1:0] CLIP_LOAD = CCNT_W'(CLIP_HOLD);
  localparam logic [IN_W-1:0]   CODE_MAX  = '1;

  typedef enum logic {WARM, ACC} state_t;

  state_t                  state_q, state_d;
  logic [WCNT_W-1:0]       warm_cnt_q, warm_cnt_d;
  logic [DCNT_W-1:0]       dec_cnt_q, dec_cnt_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CCNT_W-1:0]       clip_cnt_q, clip_cnt_d;
  logic                    clip_led_q, clip_led_d;
  logic signed [OUT_W-1:0] sample_q, sample_d;
  logic                    valid_q, valid_d;

  logic                    accept;
  logic                    emit;
  logic [ACC_W-1:0]        sum;
  logic [IN_W-1:0]         mean;
  logic [IN_W-1:0]         twos;
  logic signed [OUT_W-1:0] x;
  logic signed [OUT_W-1:0] y;

  // Datapath: running sum including the current code, truncating mean, offset-binary to signed
  always_comb begin
    accept = bus.enable && bus.adc_valid;
    sum    = acc_q + ACC_W'(bus.adc_data);
    mean   = IN_W'(sum >> DECIM_LOG2);
    twos   = {~mean[IN_W-1], mean[IN_W-2:0]};
    x      = {{(OUT_W - IN_W){twos[IN_W-1]}}, twos};
  end

  // Warm-up / accumulate sequencing; dropping enable re-arms the warm-up
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    acc_d      = acc_q;
    emit       = 1'b0;
    if (!bus.enable) begin
      state_d    = WARM;
      warm_cnt_d = '0;
      dec_cnt_d  = '0;
      acc_d      = '0;
    end else begin
      case (state_q)
        WARM: begin
          if (WARMUP == 0) begin
            state_d = ACC;
          end else if (accept) begin
            if (warm_cnt_q == WARM_LAST) begin
              state_d    = ACC;
              warm_cnt_d = '0;
              dec_cnt_d  = '0;
              acc_d      = '0;
            end else begin
              warm_cnt_d = warm_cnt_q + 1'b1;
            end
          end
        end
        ACC: begin
          if (accept) begin
            if (dec_cnt_q == DEC_LAST) begin
              emit      = 1'b1;
              acc_d     = '0;
              dec_cnt_d = '0;
            end else begin
              acc_d     = sum;
              dec_cnt_d = dec_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = WARM;
      endcase
    end
  end

  // Clip stretcher: a full-scale code reloads the hold count, otherwise it drains to zero
  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (accept && ((bus.adc_data == '0) || (bus.adc_data == CODE_MAX))) begin
      clip_cnt_d = CLIP_LOAD;
    end else if (clip_cnt_q != '0) begin
      clip_cnt_d = clip_cnt_q - 1'b1;
    end
    clip_led_d = (clip_cnt_d != '0);
  end

`ifdef ADC_DC_BLOCK_EN
  localparam int DC_W = OUT_W + DC_SHIFT;

  logic signed [DC_W-1:0]  dc_est_q, dc_est_d;
  logic signed [OUT_W-1:0] dc_mean;
  logic signed [OUT_W:0]   diff;

  // DC removal: subtract the scaled estimate, saturate, and fold the residue back into the estimate
  always_comb begin
    dc_mean = OUT_W'(dc_est_q >>> DC_SHIFT);
    diff    = {x[OUT_W-1], x} - {dc_mean[OUT_W-1], dc_mean};
    if (diff[OUT_W] != diff[OUT_W-1]) begin
      y = diff[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      y = diff[OUT_W-1:0];
    end
    dc_est_d = emit ? (dc_est_q + DC_W'(diff)) : dc_est_q;
  end

  // DC estimate register; only reset clears it, enable does not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_est_q <= '0;
    end else begin
      dc_est_q <= dc_est_d;
    end
  end
`else
  assign y = x;
`endif

  // Output staging: sample holds between strobes, strobe lasts a single cycle
  always_comb begin
    valid_d  = emit;
    sample_d = emit ? y : sample_q;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WARM;
      warm_cnt_q <= '0;
      dec_cnt_q  <= '0;
      acc_q      <= '0;
      clip_cnt_q <= '0;
      clip_led_q <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
      acc_q      <= acc_d;
      clip_cnt_q <= clip_cnt_d;
      clip_led_q <= clip_led_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.clip_led     = clip_led_q;

endmodule

// File: tb/tb_adc_decimator_frontend.sv
// Scoreboard bench for adc_decimator_frontend (DECIM_LOG2=2, WARMUP=4,
// CLIP_HOLD=100, DC_SHIFT=4). Stimulus pushes expected samples into a
// queue; an independent monitor pops them on every sample_valid strobe.
module tb_adc_decimator_frontend;

  localparam int IN_W  = 12;
  localparam int OUT_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  adc_decimator_frontend_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  adc_decimator_frontend #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DECIM_LOG2(2), .WARMUP(4),
    .CLIP_HOLD(100), .DC_SHIFT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  int          nChecks = 0;
  int          nPassed = 0;
  int          cycle = 0;
  int          validCount = 0;
  int          lastValidCycle = 0;
  int          prevValidCycle = 0;
  int          lastStrobeCycle = 0;
  logic [15:0] expQ[$];
  logic [15:0] heldExp = 16'h0000;

  // Free-running cycle index used for latency and spacing checks
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
  endtask

`ifdef ADC_DC_BLOCK_EN
  longint dcModel = 0;
  // Reference DC blocker: y = x - (est>>>4), est += that difference, y saturated
  function automatic logic [15:0] expOut(input int xIn);
    longint d;
    d = longint'(xIn) - (dcModel >>> 4);
    dcModel = dcModel + d;
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return 16'(d);
  endfunction
  task automatic resetModel();
    dcModel = 0;
  endtask
`else
  function automatic logic [15:0] expOut(input int xIn);
    return 16'(xIn);
  endfunction
  task automatic resetModel();
  endtask
`endif

  task automatic expectSample(input int xIn);
    logic [15:0] e;
    e = expOut(xIn);
    expQ.push_back(e);
    heldExp = e;
  endtask

  // Present one code for one clock (valid left high so calls can chain back-to-back)
  task automatic applyStimulus(input logic [11:0] code);
    bus.adc_valid   = 1'b1;
    bus.adc_data    = code;
    lastStrobeCycle = cycle;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.adc_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic spacedCodes(input logic [11:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(code);
      idle(1);
    end
  endtask

  // Fire a full-scale code, optionally a second one 100 cycles later, and measure the led run
  task automatic measureClip(input bit second, output int highRun);
    bit seenLow;
    seenLow       = 1'b0;
    highRun       = 0;
    bus.adc_valid = 1'b1;
    bus.adc_data  = 12'hFFF;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (bus.clip_led && !seenLow) highRun++;
      else seenLow = 1'b1;
      bus.adc_valid = (second && (i == 99));
    end
  endtask

  // Monitor: every strobe must match the oldest expected sample
  always @(negedge clk) begin
    if (rst_n && (bus.sample_valid === 1'b1)) begin
      validCount++;
      prevValidCycle = lastValidCycle;
      lastValidCycle = cycle;
      if (expQ.size() == 0) begin
        nChecks++;
        $display("[TB] FAIL unexpectedValid: got strobe with 0x%0h, want no strobe", bus.sample_out);
      end else begin
        checkOutput("sampleOut", 32'($unsigned(bus.sample_out)), 32'(expQ.pop_front()));
      end
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int vcBefore;
    int run;

    bus.enable    = 1'b1;
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resetSampleOut", 32'($unsigned(bus.sample_out)), 32'h0);
    checkOutput("resetValid", 32'(bus.sample_valid), 32'h0);
    checkOutput("resetClip", 32'(bus.clip_led), 32'h0);

    // Reset asserted while a strobe and the clip led are live
    $display("[TB] test 1: asynchronous reset mid-run");
    spacedCodes(12'hFFF, 1);
    spacedCodes(12'd100, 3);
    spacedCodes(12'hFFF, 3);
    expectSample(2047);
    bus.adc_valid = 1'b1;
    bus.adc_data  = 12'hFFF;
    @(posedge clk);
    #1;
    checkOutput("preResetValid", 32'(bus.sample_valid), 32'h1);
    checkOutput("preResetSample", 32'($unsigned(bus.sample_out)), 32'(heldExp));
    checkOutput("preResetClip", 32'(bus.clip_led), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("asyncResetSample", 32'($unsigned(bus.sample_out)), 32'h0);
    checkOutput("asyncResetValid", 32'(bus.sample_valid), 32'h0);
    checkOutput("asyncResetClip", 32'(bus.clip_led), 32'h0);
    bus.adc_valid = 1'b0;
    expQ.delete();
    resetModel();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Warm-up is silent, then a mid-scale group gives zero one clock after the last strobe
    $display("[TB] test 2: warm-up and first output");
    vcBefore = validCount;
    spacedCodes(12'd1000, 4);
    checkOutput("noWarmValid", 32'(validCount), 32'(vcBefore));
    spacedCodes(12'd2048, 3);
    expectSample(0);
    applyStimulus(12'd2048);
    idle(3);
    checkOutput("oneValid", 32'(validCount - vcBefore), 32'h1);
    checkOutput("validLatency", 32'(lastValidCycle), 32'(lastStrobeCycle + 1));

    // Back-to-back groups: -1 then +2047, strobes exactly four clocks apart
    $display("[TB] test 3: back-to-back groups");
    vcBefore = validCount;
    expectSample(-1);
    expectSample(2047);
    applyStimulus(12'd0);
    applyStimulus(12'd0);
    applyStimulus(12'hFFF);
    applyStimulus(12'hFFF);
    for (int i = 0; i < 4; i++) applyStimulus(12'hFFF);
    idle(3);
    checkOutput("twoValids", 32'(validCount - vcBefore), 32'h2);
    checkOutput("validSpacing", 32'(lastValidCycle - prevValidCycle), 32'h4);

    // Clip stretch: single hit lasts 100 clocks, a re-hit at expiry leaves no gap
    $display("[TB] test 4: clip stretch");
    idle(120);
    checkOutput("clipIdleLow", 32'(bus.clip_led), 32'h0);
    measureClip(1'b0, run);
    checkOutput("clipSingleRun", 32'(run), 32'd100);
    checkOutput("clipSingleEnd", 32'(bus.clip_led), 32'h0);
    measureClip(1'b1, run);
    checkOutput("clipRetriggerRun", 32'(run), 32'd200);

    // Complete the group opened by the three clip codes, then abort a fresh one with enable
    $display("[TB] test 5: enable drop re-arms warm-up");
    expectSample(2047);
    applyStimulus(12'hFFF);
    idle(2);
    spacedCodes(12'd2048, 2);
    bus.enable = 1'b0;
    idle(2);
    spacedCodes(12'hFFF, 3);
    vcBefore = validCount;
    bus.enable = 1'b1;
    idle(1);
    spacedCodes(12'd100, 4);
    spacedCodes(12'd1024, 3);
    checkOutput("noValidAcrossEnable", 32'(validCount), 32'(vcBefore));
    checkOutput("holdValue", 32'($unsigned(bus.sample_out)), 32'(heldExp));
    expectSample(-1024);
    applyStimulus(12'd1024);
    idle(3);
    checkOutput("validAfterRewarm", 32'(validCount - vcBefore), 32'h1);

    // Constant code 3072 from a clean reset: +1024 each output (decaying with the DC blocker)
    $display("[TB] test 6: constant input");
    rst_n = 1'b0;
    resetModel();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) applyStimulus(12'd3072);
    for (int g = 0; g < 64; g++) begin
      for (int i = 0; i < 3; i++) applyStimulus(12'd3072);
      expectSample(1024);
      applyStimulus(12'd3072);
    end
    idle(4);

    checkOutput("queueDrained", 32'(expQ.size()), 32'h0);
    $display("[TB] %0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
